// File: rtl/l2_arb_pkg.sv
// Shared types and block geometry for the L2 port arbiter; the same
// BLOCK_W/OFF_W values are used by the fetch path.
package l2_arb_pkg;

   localparam int unsigned BLOCK_W = 256;
   localparam int unsigned OFF_W   = 5;

   typedef enum logic [1:0] {
      IDLE,
      GRANT_I,
      GRANT_D
   } arb_state_t;

   typedef enum logic {
      REQ_I,
      REQ_D
   } req_id_t;

endpackage

// File: rtl/l2_arb_stats.sv
// Saturating event counters for the L2 arbiter (built only with L2_ARB_STATS_EN).
module l2_arb_stats (
   input  logic        clk,
   input  logic        rst,
   input  logic        grant_i_i,
   input  logic        grant_d_i,
   input  logic        conflict_i,
   input  logic        orphan_i,
   output logic [31:0] stat_i_grants_o,
   output logic [31:0] stat_d_grants_o,
   output logic [31:0] stat_conflicts_o,
   output logic [31:0] stat_orphans_o
);

   logic [31:0] i_grants_q, d_grants_q, conflicts_q, orphans_q;

   function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
      return (en && (v != '1)) ? v + 32'd1 : v;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         i_grants_q  <= '0;
         d_grants_q  <= '0;
         conflicts_q <= '0;
         orphans_q   <= '0;
      end else begin
         i_grants_q  <= sat_inc(i_grants_q, grant_i_i);
         d_grants_q  <= sat_inc(d_grants_q, grant_d_i);
         conflicts_q <= sat_inc(conflicts_q, conflict_i);
         orphans_q   <= sat_inc(orphans_q, orphan_i);
      end
   end

   assign stat_i_grants_o  = i_grants_q;
   assign stat_d_grants_o  = d_grants_q;
   assign stat_conflicts_o = conflicts_q;
   assign stat_orphans_o   = orphans_q;

endmodule

// File: rtl/l2_arbiter.sv
// Round-robin arbiter sharing one L2 block port between L1I and L1D.
// Optional counters are enabled with the L2_ARB_STATS_EN macro.
module l2_arbiter
   import l2_arb_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned BLOCK_W = l2_arb_pkg::BLOCK_W,
   parameter int unsigned OFF_W   = l2_arb_pkg::OFF_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_req,
   input  logic [ADDR_W-1:0]  i_addr,
   output logic [BLOCK_W-1:0] i_rdata,
   output logic               i_stall,
   input  logic               d_req,
   input  logic               d_we,
   input  logic [ADDR_W-1:0]  d_addr,
   input  logic [BLOCK_W-1:0] d_wdata,
   output logic [BLOCK_W-1:0] d_rdata,
   output logic               d_stall,
   output logic               l2_req,
   output logic               l2_we,
   output logic [ADDR_W-1:0]  l2_addr,
   output logic [BLOCK_W-1:0] l2_wdata,
   input  logic [BLOCK_W-1:0] l2_rdata,
   input  logic               l2_stall,
   output logic               busy
`ifdef L2_ARB_STATS_EN
   ,
   output logic [31:0]        stat_i_grants,
   output logic [31:0]        stat_d_grants,
   output logic [31:0]        stat_conflicts,
   output logic [31:0]        stat_orphans
`endif
);

   arb_state_t         state_q, state_d;
   req_id_t            last_q, last_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic               we_q, we_d;
   logic [BLOCK_W-1:0] wdata_q, wdata_d;
   logic               orphan_q, orphan_d;

   logic               grant_i, grant_d;
   logic               cur_req;
   logic [ADDR_W-1:0]  cur_addr;
   logic               orphan_now;
   logic               complete;
   logic               deliver;

   // Round-robin: on a tie the requester that was not served last wins.
   assign grant_i = i_req && (!d_req || (last_q == REQ_D));
   assign grant_d = d_req && (!i_req || (last_q == REQ_I));

   assign cur_req  = (state_q == GRANT_D) ? d_req  : i_req;
   assign cur_addr = (state_q == GRANT_D) ? d_addr : i_addr;

   // A read whose requester walked away is still finished on L2 but never handed back;
   // the live check lets a drop on the completion cycle itself suppress delivery.
   assign orphan_now = orphan_q ||
                       ((state_q != IDLE) && !we_q &&
                        (!cur_req || (cur_addr[ADDR_W-1:OFF_W] != addr_q[ADDR_W-1:OFF_W])));
   assign complete   = (state_q != IDLE) && !l2_stall;
   assign deliver    = complete && !orphan_now;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         last_q   <= REQ_D;
         addr_q   <= '0;
         we_q     <= 1'b0;
         wdata_q  <= '0;
         orphan_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         addr_q   <= addr_d;
         we_q     <= we_d;
         wdata_q  <= wdata_d;
         orphan_q <= orphan_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      addr_d   = addr_q;
      we_d     = we_q;
      wdata_d  = wdata_q;
      orphan_d = orphan_q;
      unique case (state_q)
         IDLE: begin
            orphan_d = 1'b0;
            if (grant_i) begin
               state_d = GRANT_I;
               last_d  = REQ_I;
               addr_d  = i_addr;
               we_d    = 1'b0;
            end else if (grant_d) begin
               state_d = GRANT_D;
               last_d  = REQ_D;
               addr_d  = d_addr;
               we_d    = d_we;
               wdata_d = d_wdata;
            end
         end
         GRANT_I, GRANT_D: begin
            if (complete) begin
               state_d  = IDLE;
               orphan_d = 1'b0;
            end else begin
               orphan_d = orphan_now;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      l2_req   = (state_q != IDLE);
      busy     = (state_q != IDLE);
      l2_we    = we_q;
      l2_addr  = addr_q;
      l2_wdata = wdata_q;
      i_stall  = !(deliver && (state_q == GRANT_I));
      d_stall  = !(deliver && (state_q == GRANT_D));
      i_rdata  = (deliver && (state_q == GRANT_I)) ? l2_rdata : '0;
      d_rdata  = (deliver && (state_q == GRANT_D) && !we_q) ? l2_rdata : '0;
   end

`ifdef L2_ARB_STATS_EN
   l2_arb_stats u_stats (
      .clk              (clk),
      .rst              (rst),
      .grant_i_i        ((state_q == IDLE) && grant_i),
      .grant_d_i        ((state_q == IDLE) && !grant_i && grant_d),
      .conflict_i       ((state_q == IDLE) && i_req && d_req),
      .orphan_i         (complete && orphan_now),
      .stat_i_grants_o  (stat_i_grants),
      .stat_d_grants_o  (stat_d_grants),
      .stat_conflicts_o (stat_conflicts),
      .stat_orphans_o   (stat_orphans)
   );
`endif

endmodule

// File: doc/l2_arbiter.md
Name: l2_arbiter

Overview:
- Shares the single L2 block-read/write port between the L1I miss path (fetch) and the L1D miss/writeback path.
- One transaction is in flight on L2 at a time. Arbitration is round-robin.
- Each requester sees the same stall/valid protocol fetch already uses: keep the request high, and the 256-bit block is valid on the cycle its stall drops.
- Sits between the L1 caches and the L2 controller.

Parameters:
- ADDR_W, 32, address width.
- BLOCK_W, 256, block width in bits.
- OFF_W, 5, block-offset bits ignored for address-match checks.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- i_req  input  1  L1I read request; level, held until its stall drops.
- i_addr  input  ADDR_W  L1I read address; passed through unaligned.
- i_rdata  output  BLOCK_W  block returned to L1I.
- i_stall  output  1  low for exactly the completion cycle of an L1I transaction; high otherwise.
- d_req  input  1  L1D request; level.
- d_we  input  1  1 = writeback, 0 = read.
- d_addr  input  ADDR_W  L1D address.
- d_wdata  input  BLOCK_W  writeback block.
- d_rdata  output  BLOCK_W  block returned to L1D.
- d_stall  output  1  same rule as i_stall, for L1D.
- l2_req  output  1  request to L2.
- l2_we  output  1  write enable to L2.
- l2_addr  output  ADDR_W  latched address to L2.
- l2_wdata  output  BLOCK_W  latched write data to L2.
- l2_rdata  input  BLOCK_W  L2 read block.
- l2_stall  input  1  L2 busy; the transaction completes on the first cycle with l2_req=1 and l2_stall=0.
- busy  output  1  high whenever the FSM is not IDLE.

Behaviour:
- Reset (rst high at a clock edge):
  - State goes to IDLE; l2_req=0, l2_we=0, l2_addr=0, l2_wdata=0.
  - i_stall=1, d_stall=1, busy=0, round-robin pointer last=D.
  - Reset mid-transaction abandons it silently; L2 must tolerate l2_req dropping.
- States: IDLE, GRANT_I, GRANT_D.
- IDLE:
  - If exactly one request is high, grant it.
  - If both are high, grant the requester not equal to last.
  - On grant, latch addr (plus we/wdata for D) into the l2_* registers, set l2_req=1 next cycle, and update last.
  - Minimum latency: request seen at edge N, l2_req high from N+1.
- GRANT_x, l2_req=1, l2_stall=1: hold everything; no re-arbitration.
- GRANT_x, l2_req=1, l2_stall=0 (completion):
  - x_stall goes low combinationally this cycle.
  - x_rdata = l2_rdata (combinational passthrough; zero for writes).
  - Next state is IDLE, l2_req=0.
  - If the requester still holds req the following cycle, that is a new request.
- The idle cycle after each completion is mandatory: back-to-back transactions are at least 2 cycles apart.
- Orphan rule (fetch mispredict):
  - While granted, if x_req drops, or x_addr[ADDR_W-1:OFF_W] differs from the latched l2_addr block bits, set the orphan flag.
  - An orphaned transaction still completes on L2, but x_stall stays high and the result is discarded.
  - The orphan flag clears on completion.
  - A new address is arbitrated normally afterwards.
- Writes are never orphaned. A d_req drop during a write is a protocol violation; the write completes anyway.
- The non-granted requester's stall stays 1 throughout.
- Both stalls are 1 in IDLE, including when no request is pending.
- i_rdata/d_rdata are zero when not completing.

Optional Feature:
- Macro L2_ARB_STATS_EN.
- Defined:
  - Adds 32-bit saturating counters stat_i_grants, stat_d_grants, stat_conflicts and stat_orphans as outputs. stat_conflicts counts IDLE cycles with both requests high.
  - Counters clear on rst.
- Undefined: these ports and their logic are absent; core behaviour is identical.

Decomposition:
- Package l2_arb_pkg holds:
  - enum arb_state_t {IDLE, GRANT_I, GRANT_D};
  - enum req_id_t {REQ_I, REQ_D};
  - BLOCK_W/OFF_W constants shared with fetch.
- One sub-module, l2_arb_stats, holds the counters. It is instantiated only under L2_ARB_STATS_EN.

Test Plan:
- i_req=1, i_addr=0, l2_stall=1 for 4 cycles, then l2_stall=0 with l2_rdata={32'h0..32'h7}:
  - l2_addr=0 throughout; i_stall low for exactly 1 cycle; i_rdata[31:0]=7.
- i_req and d_req both rise the same cycle after reset:
  - D is not granted first (last=D at reset), so I is granted first; D is granted in the IDLE cycle after I completes.
  - l2_addr follows i_addr, then d_addr.
- Granted I at address 0; at cycle 2 i_addr becomes 964 with i_req held:
  - The 0 transaction completes with i_stall high.
  - The next grant has l2_addr=964; when l2_rdata arrives, i_rdata carries 32'h33333333 in bits [95:64].
- d_req=1, d_we=1, d_addr=32'h40, d_wdata all 32'hA5A5A5A5:
  - l2_we=1, l2_wdata is latched, and the latched values stay stable when d_wdata changes mid-stall.
- rst asserted while in GRANT_D with l2_stall=1:
  - Next cycle: l2_req=0, busy=0, both stalls=1.
- With L2_ARB_STATS_EN, after the conflict and orphan tests above:
  - stat_conflicts=1, stat_orphans=1, stat_i_grants=3.
